// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared constants and types for the 5-stage RISC-V core.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int          XLEN_DEFAULT      = 32;
  localparam int          CNT_W_DEFAULT     = 16;
  localparam int          INSTR_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  // What the IF/ID register does on a given edge, highest priority first.
  typedef enum logic [2:0] {
    ACT_IDLE     = 3'd0,  // not yet running: hold everything
    ACT_REDIRECT = 3'd1,  // taken branch/jump: flush and reload PC
    ACT_STALL    = 3'd2,  // load-use stall: hold PC and IF/ID
    ACT_LOAD     = 3'd3,  // fetch completed: capture instruction
    ACT_BUBBLE   = 3'd4   // fetch still waiting: insert NOP
  } if_action_e;

endpackage
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Program counter with +4 increment, word-aligned redirect and a
//            sticky flag recording any misaligned redirect target.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc,
  output logic            misalign
);

  logic [XLEN-1:0] pc_d, pc_q;
  logic            misalign_d, misalign_q;

  // Next PC: redirect wins over sequential advance; arithmetic wraps freely.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (redirect) begin
      pc_d       = {target[XLEN-1:2], 2'b00};
      misalign_d = misalign_q | (target[1:0] != 2'b00);
    end else if (load_en) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  // PC and sticky misalign flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc       = pc_q;
  assign misalign = misalign_q;

endmodule
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage
// Purpose  : Fetch stage plus IF/ID pipeline register. Drives instruction
//            memory from the PC, captures fetched words, honours load-use
//            stalls and EX redirects, and counts stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_stage
  import riscv_pkg::*;
#(
  parameter int                 XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]    RESET_PC  = XLEN'(RESET_PC_DEFAULT),
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int                 CNT_W     = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hdu_stall,
  input  logic               ex_redirect,
  input  logic [XLEN-1:0]    ex_redirect_pc,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [XLEN-1:0]    id_pc,
  output logic [XLEN-1:0]    id_pc_plus4,
  output logic [INSTR_W-1:0] id_instr,
  output logic               id_valid,
  output logic               id_misalign,
  output logic [CNT_W-1:0]   perf_stall_cycles
);

  logic               run_d, run_q;
  logic [XLEN-1:0]    id_pc_d, id_pc_q;
  logic [XLEN-1:0]    id_pc_plus4_d, id_pc_plus4_q;
  logic [INSTR_W-1:0] id_instr_d, id_instr_q;
  logic               id_valid_d, id_valid_q;
  logic [CNT_W-1:0]   stall_cnt_d, stall_cnt_q;
  logic [XLEN-1:0]    pc;
  logic               fetch_done;
  if_action_e         action;

  assign imem_req   = run_q & ~hdu_stall;
  assign imem_addr  = pc;
  assign fetch_done = imem_req & imem_ready;

  pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (action == ACT_LOAD),
    .redirect (action == ACT_REDIRECT),
    .target   (ex_redirect_pc),
    .pc       (pc),
    .misalign (id_misalign)
  );

  // Resolve this edge's action: redirect > stall > fetch complete > wait.
  always_comb begin
    action = ACT_IDLE;
    if (run_q) begin
      if (ex_redirect)     action = ACT_REDIRECT;
      else if (hdu_stall)  action = ACT_STALL;
      else if (fetch_done) action = ACT_LOAD;
      else                 action = ACT_BUBBLE;
    end
  end

  // IF/ID next state, run flag and saturating stall counter.
  always_comb begin
    run_d         = 1'b1;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_instr_d    = id_instr_q;
    id_valid_d    = id_valid_q;
    stall_cnt_d   = stall_cnt_q;
    case (action)
      ACT_REDIRECT, ACT_BUBBLE: begin
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
      end
      ACT_LOAD: begin
        id_pc_d       = pc;
        id_pc_plus4_d = pc + XLEN'(4);
        id_instr_d    = imem_rdata;
        id_valid_d    = 1'b1;
      end
      default: ;
    endcase
    // Stall cycles count even when a redirect overrides the stall.
    if (run_q && hdu_stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // IF/ID pipeline register, run flag and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      id_pc_q       <= RESET_PC;
      id_pc_plus4_q <= RESET_PC + XLEN'(4);
      id_instr_q    <= NOP_INSTR;
      id_valid_q    <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      run_q         <= run_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_instr_q    <= id_instr_d;
      id_valid_q    <= id_valid_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign id_pc             = id_pc_q;
  assign id_pc_plus4       = id_pc_plus4_q;
  assign id_instr          = id_instr_q;
  assign id_valid          = id_valid_q;
  assign perf_stall_cycles = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_stage
// Purpose  : Self-checking bench for if_id_stage with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hdu_stall = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc, id_pc_plus4, id_instr;
  logic        id_valid, id_misalign;
  logic [15:0] perf_stall_cycles;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Instruction memory contents derived from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h0000_0033;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_id_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .hdu_stall         (hdu_stall),
    .ex_redirect       (ex_redirect),
    .ex_redirect_pc    (ex_redirect_pc),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ready        (imem_ready),
    .imem_rdata        (imem_rdata),
    .id_pc             (id_pc),
    .id_pc_plus4       (id_pc_plus4),
    .id_instr          (id_instr),
    .id_valid          (id_valid),
    .id_misalign       (id_misalign),
    .perf_stall_cycles (perf_stall_cycles)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_run = 0;
  logic [31:0] m_pc = 32'h0, m_id_pc = 32'h0, m_id_instr = NOP;
  bit          m_valid = 0, m_mis = 0;
  int          m_cnt = 0;

  always @(negedge rst_n) begin
    m_run = 0; m_pc = 32'h0; m_id_pc = 32'h0; m_id_instr = NOP;
    m_valid = 0; m_mis = 0; m_cnt = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (!m_run) begin
        m_run = 1;
      end else begin
        if (hdu_stall && m_cnt < 65535) m_cnt = m_cnt + 1;
        if (ex_redirect) begin
          m_pc       = ex_redirect_pc & 32'hFFFF_FFFC;
          m_valid    = 0;
          m_id_instr = NOP;
          if (ex_redirect_pc % 4 != 0) m_mis = 1;
        end else if (hdu_stall) begin
          // everything holds
        end else if (imem_ready) begin
          m_id_pc    = m_pc;
          m_id_instr = mem_word(m_pc);
          m_valid    = 1;
          m_pc       = m_pc + 32'd4;
        end else begin
          m_valid    = 0;
          m_id_instr = NOP;
        end
      end
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("imem_req",    {31'b0, imem_req},    {31'b0, m_run && !hdu_stall});
      cmp("imem_addr",   imem_addr,            m_pc);
      cmp("id_pc",       id_pc,                m_id_pc);
      cmp("id_pc_plus4", id_pc_plus4,          m_id_pc + 32'd4);
      cmp("id_instr",    id_instr,             m_id_instr);
      cmp("id_valid",    {31'b0, id_valid},    {31'b0, m_valid});
      cmp("id_misalign", {31'b0, id_misalign}, {31'b0, m_mis});
      cmp("perf_cnt",    {16'b0, perf_stall_cycles}, m_cnt[31:0]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    cyc(2);
    cmp("rst_id_pc",    id_pc, 32'h0);
    cmp("rst_plus4",    id_pc_plus4, 32'h4);
    cmp("rst_instr",    id_instr, NOP);
    cmp("rst_valid",    {31'b0, id_valid}, 32'h0);
    cmp("rst_req",      {31'b0, imem_req}, 32'h0);
    cmp("rst_cnt",      {16'b0, perf_stall_cycles}, 32'h0);

    // Sequential fetch from reset.
    rst_n = 1'b1;
    cyc(1); cmp("seq_addr0", imem_addr, 32'h0); cmp("seq_req", {31'b0, imem_req}, 32'h1);
    cyc(1); cmp("seq_addr4", imem_addr, 32'h4); cmp("seq_idpc0", id_pc, 32'h0);
            cmp("seq_valid", {31'b0, id_valid}, 32'h1);
            cmp("seq_instr0", id_instr, 32'h5A5A_0033);
    cyc(1); cmp("seq_addr8", imem_addr, 32'h8); cmp("seq_idpc4", id_pc, 32'h4);
    cyc(1); cmp("seq_idpc8", id_pc, 32'h8);

    // Three-cycle load-use stall.
    hdu_stall = 1'b1; #1;
    cmp("stall_req", {31'b0, imem_req}, 32'h0);
    cyc(3);
    cmp("stall_idpc", id_pc, 32'h8);
    cmp("stall_instr", id_instr, mem_word(32'h8));
    cmp("stall_cnt", {16'b0, perf_stall_cycles}, 32'd3);
    cmp("stall_addr", imem_addr, 32'd12);
    hdu_stall = 1'b0;
    cyc(1); cmp("resume_idpc", id_pc, 32'd12);

    // Redirect together with stall and ready.
    ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_0100; hdu_stall = 1'b1;
    cyc(1);
    cmp("redir_valid", {31'b0, id_valid}, 32'h0);
    cmp("redir_instr", id_instr, 32'h0000_0013);
    cmp("redir_pc", imem_addr, 32'h100);
    ex_redirect = 1'b0; hdu_stall = 1'b0;
    cyc(1); cmp("redir_fetch", id_pc, 32'h100);

    // Misaligned redirect then an aligned one.
    ex_redirect = 1'b1; ex_redirect_pc = 32'h0000_0102;
    cyc(1); cmp("mis_pc", imem_addr, 32'h100); cmp("mis_flag", {31'b0, id_misalign}, 32'h1);
    ex_redirect_pc = 32'h0000_0200;
    cyc(1); cmp("mis_sticky", {31'b0, id_misalign}, 32'h1);

    // Two wait cycles.
    ex_redirect = 1'b0; imem_ready = 1'b0;
    cyc(2); cmp("wait_valid", {31'b0, id_valid}, 32'h0); cmp("wait_pc", imem_addr, 32'h200);
    imem_ready = 1'b1;
    cyc(1); cmp("wait_done", id_pc, 32'h200);

    // PC wrap-around.
    ex_redirect = 1'b1; ex_redirect_pc = 32'hFFFF_FFFC;
    cyc(1); ex_redirect = 1'b0;
    cyc(1);
    cmp("wrap_idpc", id_pc, 32'hFFFF_FFFC);
    cmp("wrap_plus4", id_pc_plus4, 32'h0);
    cmp("wrap_addr", imem_addr, 32'h0);

    // Asynchronous reset in the middle of a stall.
    hdu_stall = 1'b1;
    cyc(2);
    rst_n = 1'b0; #1;
    cmp("arst_valid", {31'b0, id_valid}, 32'h0);
    cmp("arst_mis", {31'b0, id_misalign}, 32'h0);
    cmp("arst_cnt", {16'b0, perf_stall_cycles}, 32'h0);
    cmp("arst_addr", imem_addr, 32'h0);
    cyc(1); rst_n = 1'b1; hdu_stall = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      rst_n       = ($urandom_range(0, 199) != 0);
      hdu_stall   = ($urandom_range(0, 3) == 0);
      ex_redirect = ($urandom_range(0, 9) == 0);
      imem_ready  = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       ex_redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
        1:       ex_redirect_pc = $urandom();
        default: ex_redirect_pc = $urandom() & 32'h0000_0FFC;
      endcase
    end

    // Long stall saturates the counter.
    cyc(1);
    rst_n = 1'b1; ex_redirect = 1'b0; imem_ready = 1'b1; hdu_stall = 1'b0;
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    hdu_stall = 1'b1;
    cyc(65540);
    cmp("sat_cnt", {16'b0, perf_stall_cycles}, 32'h0000_FFFF);
    hdu_stall = 1'b0;
    cyc(2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Fetch stage plus IF/ID pipeline register for the 5-stage RISC-V core.
- Owns the PC and drives instruction-memory requests.
- Captures fetched instructions into the IF/ID register.
- Obeys the load-use stall from the hazard detection unit and the branch/jump redirect from EX.
- Its outputs feed the ID stage, whose register addresses feed the hazard detection unit.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- hdu_stall  in  1  load-use stall from hazard detection; hold PC and IF/ID.
- ex_redirect  in  1  taken branch/jump resolved in EX; flush and redirect.
- ex_redirect_pc  in  XLEN  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address (= PC).
- imem_ready  in  1  imem_rdata valid this cycle for imem_addr.
- imem_rdata  in  32  fetched instruction.
- id_pc  out  XLEN  PC of the instruction in IF/ID.
- id_pc_plus4  out  XLEN  id_pc + 4.
- id_instr  out  32  instruction in IF/ID.
- id_valid  out  1  IF/ID holds a real instruction.
- id_misalign  out  1  sticky: a redirect target had bits[1:0] != 0.
- perf_stall_cycles  out  CNT_W  saturating count of hdu_stall cycles.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-fetch):
  - pc=RESET_PC; id_pc=RESET_PC; id_pc_plus4=RESET_PC+4; id_instr=NOP_INSTR.
  - id_valid=0; id_misalign=0; perf_stall_cycles=0.
  - Internal run flag=0, so imem_req=0.
- Run flag sets on the first clk rising edge after rst_n deasserts. imem_req = run & ~hdu_stall. imem_addr = pc at all times.
- A fetch completes in a cycle where imem_req & imem_ready. imem_rdata is sampled at that edge; latency is 1 cycle from completion to id_* update.
- Per-edge priority (run=1): redirect > stall > fetch complete > fetch wait.
  - ex_redirect=1 (regardless of stall or imem_ready):
    - pc <= {ex_redirect_pc[XLEN-1:2],2'b00}.
    - id_valid <= 0; id_instr <= NOP_INSTR.
    - Any completing fetch is discarded.
    - id_misalign <= id_misalign | (ex_redirect_pc[1:0]!=0).
  - hdu_stall=1: pc, id_pc, id_pc_plus4, id_instr and id_valid all hold. imem_req is low, so no fetch completes.
  - Fetch complete:
    - id_pc <= pc; id_pc_plus4 <= pc+4; id_instr <= imem_rdata; id_valid <= 1.
    - pc <= pc+4.
  - Fetch wait (imem_ready=0): pc holds; id_valid <= 0; id_instr <= NOP_INSTR (bubble).
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 wraps to 0, with no flag.
- perf_stall_cycles increments on each edge with run & hdu_stall, saturating at all-ones. Counting applies even when ex_redirect is also high.
- Redirect and stall in the same cycle: the redirect wins and the stall is ignored for PC/IF-ID. The stalled instruction is younger than the branch and must die.
- Stall held for N cycles: IF/ID is unchanged for N cycles, then the next fetch proceeds from the same pc.
- No combinational path from imem_rdata to any output. Only imem_req depends combinationally on hdu_stall.

Decomposition:
- Shared package riscv_pkg holds XLEN, NOP_INSTR, the RESET_PC default and CNT_W.
- One sub-module is natural: pc_gen. It holds the PC register, the +4 adder, redirect alignment and the misalign flag. It takes load_en, redirect and target, and outputs pc.
- The IF/ID register, run flag and perf counter stay in if_id_stage.

Test Plan:
- Reset then imem_ready=1 always, rdata=addr-derived: imem_addr reads 0,4,8 on consecutive cycles. id_pc/id_instr follow one cycle later; id_valid=1 from the second edge.
- hdu_stall high 3 cycles with id_pc=8: imem_req=0 during the stall; id_pc=8 and id_instr held for 3 edges; perf_stall_cycles=3; fetch resumes at addr 12.
- ex_redirect with target 32'h0000_0100 while imem_ready=1 and hdu_stall=1: next edge id_valid=0, id_instr=32'h0000_0013, pc=0x100; next fetch addr 0x100.
- Redirect to 32'h0000_0102: pc=0x100, id_misalign=1; it stays 1 after later aligned redirects until reset.
- imem_ready low 2 cycles: two bubbles (id_valid=0, NOP), pc unchanged; the fetch then completes with correct id_pc.
- Redirect to 32'hFFFF_FFFC, then a fetch completes: id_pc=FFFF_FFFC, id_pc_plus4=0, next imem_addr=0. Separately, assert rst_n low mid-stall: outputs return to reset values immediately, and the counter saturates at 16'hFFFF under a long stall.
